// File: rtl/arithmetic_addsub_seq_if.sv
// Request/response bundle for the chunked adder/subtractor.
// Request side: in_valid/in_ready; response side: out_valid/out_ready.
// master issues requests and consumes results; slave is the adder itself.
interface arithmetic_addsub_seq_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 sub_mode;
  logic                 use_carry;
  logic                 in_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] sum;
  logic                 carry;
  logic                 overflow;
  logic                 zero;
  logic                 negative;

  modport master (
    output in_valid, a, b, sub_mode, use_carry, in_carry, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, sub_mode, use_carry, in_carry, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/arithmetic_addsub_seq.sv
// Sequential add/subtract, CHUNK_WIDTH bits per cycle, with carry/overflow/zero/negative flags.
// Latency: out_valid rises NUM_CHUNKS cycles after the accepting edge.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module arithmetic_addsub_seq #(
  parameter int BIT_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  arithmetic_addsub_seq_if.slave bus
);
  localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [BIT_WIDTH-1:0] CHUNK_ONES = BIT_WIDTH'({CHUNK_WIDTH{1'b1}});

  if ((BIT_WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
    $error("BIT_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  // operands captured at accept; b is stored already inverted for subtraction
  logic [BIT_WIDTH-1:0]   a_q, bx_q;
  logic [BIT_WIDTH-1:0]   work_q, work_d;   // partial result, never exposed
  logic [IDX_W-1:0]       idx_q;
  logic                   carry_q;          // running carry between chunks
  logic                   last_chunk;

  // result registers, only written when entering DONE
  logic [BIT_WIDTH-1:0]   sum_q;
  logic                   carry_out_q, overflow_q, zero_q, negative_q;

  logic [31:0]            shift;
  logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk;
  logic [CHUNK_WIDTH:0]   chunk_sum;
  logic                   msb_carry_in;

  assign last_chunk = (idx_q == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake outputs; DONE always returns to IDLE so no same-cycle re-accept
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // one chunk of the ripple: select chunk idx, add with running carry, merge into partial result
  always_comb begin
    shift        = 32'(idx_q) * 32'(CHUNK_WIDTH);
    a_chunk      = CHUNK_WIDTH'(a_q >> shift);
    b_chunk      = CHUNK_WIDTH'(bx_q >> shift);
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
    work_d       = (work_q & ~(CHUNK_ONES << shift))
                 | (BIT_WIDTH'(chunk_sum[CHUNK_WIDTH-1:0]) << shift);
    // carry into the top bit recovered from its sum bit and operand bits
    msb_carry_in = work_d[BIT_WIDTH-1] ^ a_q[BIT_WIDTH-1] ^ bx_q[BIT_WIDTH-1];
  end

  // operand capture, chunk iteration, and result/flag update on the final chunk
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      bx_q        <= '0;
      work_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            bx_q    <= bus.b ^ {BIT_WIDTH{bus.sub_mode}};
            carry_q <= bus.use_carry ? bus.in_carry : bus.sub_mode;
            idx_q   <= '0;
            work_q  <= '0;
          end
        end
        BUSY: begin
          work_q  <= work_d;
          carry_q <= chunk_sum[CHUNK_WIDTH];
          idx_q   <= last_chunk ? '0 : idx_q + 1'b1;
          if (last_chunk) begin
            sum_q       <= work_d;
            carry_out_q <= chunk_sum[CHUNK_WIDTH];
            overflow_q  <= msb_carry_in ^ chunk_sum[CHUNK_WIDTH];
            zero_q      <= (work_d == '0);
            negative_q  <= work_d[BIT_WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.carry    = carry_out_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;

endmodule
